// File: rtl/lsu_ctrl.sv
// Load/store unit controller: one decoded load/store per transaction onto a req/gnt/rvalid memory port.
// Optional macro LSU_MISALIGN_TRAP_EN traps misaligned H/W accesses instead of silently aligning them.
module lsu_ctrl #(
    parameter int XLEN      = 32,
    parameter int TIMEOUT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic              i_is_store,
    input  logic [2:0]        i_f3,
    input  logic [XLEN-1:0]   i_addr,
    input  logic [XLEN-1:0]   i_wdata,
    input  logic [4:0]        i_rd,
    output logic              o_mem_req,
    input  logic              i_mem_gnt,
    output logic              o_mem_we,
    output logic [XLEN-1:0]   o_mem_addr,
    output logic [XLEN/8-1:0] o_mem_be,
    output logic [XLEN-1:0]   o_mem_wdata,
    input  logic              i_mem_rvalid,
    input  logic [XLEN-1:0]   i_mem_rdata,
    output logic              o_wb_valid,
    output logic [4:0]        o_wb_rd,
    output logic [XLEN-1:0]   o_wb_data,
    output logic              o_err
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    output logic              o_exc_misalign
`endif
);

    localparam int BE_W  = XLEN / 8;
    localparam int OFF_W = $clog2(BE_W);
    localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'((1 << TIMEOUT_W) - 2);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, ERR} state_t;

    state_t              state_q, state_d;
    logic                is_store_q, is_store_d;
    logic [2:0]          f3_q, f3_d;
    logic [XLEN-1:0]     addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [4:0]          rd_q, rd_d;
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic                wb_valid_q, wb_valid_d;
    logic [4:0]          wb_rd_q, wb_rd_d;
    logic [XLEN-1:0]     wb_data_q, wb_data_d;

    logic                in_illegal;
    logic [OFF_W-1:0]    off;
    logic [BE_W-1:0]     be_base;
    logic [XLEN-1:0]     wdata_rep;
    logic [XLEN-1:0]     rdata_sh;
    logic [XLEN-1:0]     ld_ext;

    function automatic logic f3_illegal(input logic is_store, input logic [2:0] f3);
        if (is_store) return (f3 > 3'b010);
        return (f3 == 3'b011) || (f3[2:1] == 2'b11);
    endfunction

`ifdef LSU_MISALIGN_TRAP_EN
    function automatic logic misaligned(input logic [2:0] f3, input logic [OFF_W-1:0] lo);
        return ((f3[1:0] == 2'b01) && lo[0]) || ((f3[1:0] == 2'b10) && (lo[1:0] != 2'b00));
    endfunction

    assign in_illegal = f3_illegal(i_is_store, i_f3) ||
                        (!f3_illegal(i_is_store, i_f3) && misaligned(i_f3, i_addr[OFF_W-1:0]));
    assign o_exc_misalign = (state_q == ERR) && !f3_illegal(is_store_q, f3_q) &&
                            misaligned(f3_q, addr_q[OFF_W-1:0]);
`else
    assign in_illegal = f3_illegal(i_is_store, i_f3);
`endif

    // Lane offset; without the trap, misaligned halves/words are forced onto their natural boundary.
    always_comb begin
        off = addr_q[OFF_W-1:0];
`ifndef LSU_MISALIGN_TRAP_EN
        if (f3_q[1:0] == 2'b01) off[0] = 1'b0;
        if (f3_q[1:0] == 2'b10) off[1:0] = 2'b00;
`endif
    end

    always_comb begin
        be_base   = BE_W'(4'b0001);
        wdata_rep = {BE_W{wdata_q[7:0]}};
        case (f3_q[1:0])
            2'b00: begin
                be_base   = BE_W'(4'b0001);
                wdata_rep = {BE_W{wdata_q[7:0]}};
            end
            2'b01: begin
                be_base   = BE_W'(4'b0011);
                wdata_rep = {(XLEN/16){wdata_q[15:0]}};
            end
            default: begin
                be_base   = BE_W'(4'b1111);
                wdata_rep = {(XLEN/32){wdata_q[31:0]}};
            end
        endcase
    end

    assign rdata_sh = i_mem_rdata >> {off, 3'b000};

    always_comb begin
        ld_ext = XLEN'($signed(rdata_sh[31:0]));
        case (f3_q)
            3'b000:  ld_ext = XLEN'($signed(rdata_sh[7:0]));
            3'b001:  ld_ext = XLEN'($signed(rdata_sh[15:0]));
            3'b100:  ld_ext = XLEN'(rdata_sh[7:0]);
            3'b101:  ld_ext = XLEN'(rdata_sh[15:0]);
            default: ld_ext = XLEN'($signed(rdata_sh[31:0]));
        endcase
    end

    always_comb begin
        state_d    = state_q;
        is_store_d = is_store_q;
        f3_d       = f3_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rd_d       = rd_q;
        cnt_d      = cnt_q;
        wb_valid_d = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (i_valid) begin
                    is_store_d = i_is_store;
                    f3_d       = i_f3;
                    addr_d     = i_addr;
                    wdata_d    = i_wdata[31:0];
                    rd_d       = i_rd;
                    state_d    = in_illegal ? ERR : REQ;
                end
            end
            REQ: begin
                cnt_d = '0;
                if (i_mem_gnt) state_d = is_store_q ? IDLE : WAIT;
            end
            WAIT: begin
                // A timeout reuses ERR so both error sources share the single o_err pulse.
                if (i_mem_rvalid) begin
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    wb_data_d  = ld_ext;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) state_d = ERR;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            is_store_q <= 1'b0;
            f3_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            is_store_q <= is_store_d;
            f3_q       <= f3_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
        end
    end

    assign o_ready     = (state_q == IDLE);
    assign o_mem_req   = (state_q == REQ);
    assign o_mem_we    = (state_q == REQ) && is_store_q;
    assign o_mem_addr  = (state_q == REQ) ? {addr_q[XLEN-1:OFF_W], {OFF_W{1'b0}}} : '0;
    assign o_mem_be    = (state_q == REQ) ? (be_base << off) : '0;
    assign o_mem_wdata = (state_q == REQ) ? wdata_rep : '0;
    assign o_err       = (state_q == ERR);
    assign o_wb_valid  = wb_valid_q;
    assign o_wb_rd     = wb_rd_q;
    assign o_wb_data   = wb_data_q;

endmodule
